// File: rtl/ones_stat.sv
// ones_stat: accumulates FRAME_LEN popcounts into sum/min/max and offers each frame through a held valid/ready register, with drop and range-error flags.
module ones_stat #(
  parameter int WIDTH     = 32,
  parameter int FRAME_LEN = 16,
  parameter int CNT_W     = $clog2(WIDTH) + 2,
  parameter int SUM_W     = $clog2(FRAME_LEN * WIDTH + 1)
) (
  input  logic             clk_i,
  input  logic             arst_n_i,
  input  logic             data_val_i,
  input  logic [CNT_W-1:0] data_i,
  input  logic             clr_i,
  input  logic             frame_rdy_i,
  output logic             frame_val_o,
  output logic [SUM_W-1:0] sum_o,
  output logic [CNT_W-1:0] min_o,
  output logic [CNT_W-1:0] max_o,
  output logic             drop_o,
  output logic             ovf_o,
  output logic             range_err_o
);
  localparam int IDX_W = FRAME_LEN > 1 ? $clog2(FRAME_LEN) : 1;
  typedef enum logic {EMPTY, FULL} state_t;
  state_t state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [SUM_W-1:0] acc_sum_q, acc_sum_d, sum_q, sum_d, new_sum;
  logic [CNT_W-1:0] acc_min_q, acc_min_d, acc_max_q, acc_max_d, min_q, min_d, max_q, max_d;
  logic [CNT_W-1:0] sat, new_min, new_max;
  logic drop_q, drop_d, ovf_q, ovf_d, range_err_q, range_err_d;
  logic acc, first, last, load, drop, too_big;
  always_comb begin
    too_big     = data_i > CNT_W'(WIDTH);
    sat         = too_big ? CNT_W'(WIDTH) : data_i;
    acc         = data_val_i & ~clr_i;
    first       = idx_q == '0;
    last        = acc & (idx_q == IDX_W'(FRAME_LEN - 1));
    new_sum     = first ? SUM_W'(sat) : acc_sum_q + SUM_W'(sat);
    new_min     = (first || sat < acc_min_q) ? sat : acc_min_q;
    new_max     = (first || sat > acc_max_q) ? sat : acc_max_q;
    load        = last & (state_q == EMPTY | frame_rdy_i);
    drop        = last & state_q == FULL & ~frame_rdy_i;
    idx_d       = (clr_i | last) ? '0 : acc ? idx_q + 1'b1 : idx_q;
    acc_sum_d   = acc ? new_sum : acc_sum_q;
    acc_min_d   = acc ? new_min : acc_min_q;
    acc_max_d   = acc ? new_max : acc_max_q;
    sum_d       = load ? new_sum : sum_q;
    min_d       = load ? new_min : min_q;
    max_d       = load ? new_max : max_q;
    state_d     = (load | (state_q == FULL & ~frame_rdy_i)) ? FULL : EMPTY;
    drop_d      = drop;
    ovf_d       = ovf_q | drop;
    range_err_d = range_err_q | (acc & too_big);
  end
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q     <= EMPTY;
      idx_q       <= '0;
      acc_sum_q   <= '0;
      acc_min_q   <= '0;
      acc_max_q   <= '0;
      sum_q       <= '0;
      min_q       <= '0;
      max_q       <= '0;
      drop_q      <= 1'b0;
      ovf_q       <= 1'b0;
      range_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      acc_sum_q   <= acc_sum_d;
      acc_min_q   <= acc_min_d;
      acc_max_q   <= acc_max_d;
      sum_q       <= sum_d;
      min_q       <= min_d;
      max_q       <= max_d;
      drop_q      <= drop_d;
      ovf_q       <= ovf_d;
      range_err_q <= range_err_d;
    end
  end
  assign frame_val_o = state_q == FULL;
  assign sum_o       = sum_q;
  assign min_o       = min_q;
  assign max_o       = max_q;
  assign drop_o      = drop_q;
  assign ovf_o       = ovf_q;
  assign range_err_o = range_err_q;
endmodule

// File: tb/tb_ones_stat.sv
// tb_ones_stat: directed checks of ones_stat with WIDTH=32, FRAME_LEN=4.
module tb_ones_stat;
  localparam int WIDTH = 32;
  localparam int FRAME_LEN = 4;
  localparam int CNT_W = $clog2(WIDTH) + 2;
  localparam int SUM_W = $clog2(FRAME_LEN * WIDTH + 1);
  logic clk = 1'b0;
  logic arst_n = 1'b0;
  logic data_val = 1'b0;
  logic [CNT_W-1:0] data = '0;
  logic clr = 1'b0;
  logic rdy = 1'b0;
  logic frame_val, drop, ovf, range_err;
  logic [SUM_W-1:0] sum;
  logic [CNT_W-1:0] mn, mx;
  int errs = 0;
  int checks = 0;
  ones_stat #(.WIDTH(WIDTH), .FRAME_LEN(FRAME_LEN)) dut (
    .clk_i(clk), .arst_n_i(arst_n), .data_val_i(data_val), .data_i(data),
    .clr_i(clr), .frame_rdy_i(rdy), .frame_val_o(frame_val), .sum_o(sum),
    .min_o(mn), .max_o(mx), .drop_o(drop), .ovf_o(ovf), .range_err_o(range_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic tick(input logic v, input int d, input logic c, input logic r);
    @(negedge clk);
    data_val = v;
    data = CNT_W'(d);
    clr = c;
    rdy = r;
  endtask
  task automatic chk_all_zero(input string tag);
    chk({tag, "_val"}, int'(frame_val), 0);
    chk({tag, "_sum"}, int'(sum), 0);
    chk({tag, "_min"}, int'(mn), 0);
    chk({tag, "_max"}, int'(mx), 0);
    chk({tag, "_drop"}, int'(drop), 0);
    chk({tag, "_ovf"}, int'(ovf), 0);
    chk({tag, "_rerr"}, int'(range_err), 0);
  endtask
  initial begin
    #3;
    chk_all_zero("rst");
    @(negedge clk);
    arst_n = 1'b1;
    repeat (3) tick(0, 0, 0, 0);
    chk("idle_val", int'(frame_val), 0);
    tick(1, 3, 0, 1);
    tick(1, 7, 0, 1);
    tick(1, 0, 0, 1);
    tick(1, 32, 0, 1);
    tick(0, 0, 0, 1);
    chk("basic_val", int'(frame_val), 1);
    chk("basic_sum", int'(sum), 42);
    chk("basic_min", int'(mn), 0);
    chk("basic_max", int'(mx), 32);
    tick(0, 0, 0, 0);
    chk("basic_xfer", int'(frame_val), 0);
    for (int i = 0; i < 8; i++) begin
      tick(1, 5, 0, 0);
      if (i == 4) begin
        chk("stall_val", int'(frame_val), 1);
        chk("stall_sum", int'(sum), 20);
        chk("stall_min", int'(mn), 5);
        chk("stall_max", int'(mx), 5);
      end
      if (i > 0) chk("stall_nodrop", int'(drop), 0);
    end
    tick(0, 0, 0, 0);
    chk("drop_pulse", int'(drop), 1);
    chk("drop_ovf", int'(ovf), 1);
    chk("drop_keep_sum", int'(sum), 20);
    chk("drop_keep_val", int'(frame_val), 1);
    tick(0, 0, 0, 1);
    chk("drop_one_cycle", int'(drop), 0);
    tick(0, 0, 0, 0);
    chk("drain_val", int'(frame_val), 0);
    chk("ovf_sticky", int'(ovf), 1);
    repeat (4) tick(1, 1, 0, 0);
    tick(0, 0, 0, 0);
    chk("hold_val", int'(frame_val), 1);
    chk("hold_sum", int'(sum), 4);
    repeat (3) tick(1, 2, 0, 0);
    tick(1, 2, 0, 1);
    tick(0, 0, 0, 0);
    chk("coinc_val", int'(frame_val), 1);
    chk("coinc_sum", int'(sum), 8);
    chk("coinc_min", int'(mn), 2);
    chk("coinc_max", int'(mx), 2);
    chk("coinc_nodrop", int'(drop), 0);
    tick(0, 0, 0, 1);
    tick(0, 0, 0, 1);
    chk("coinc_drain", int'(frame_val), 0);
    tick(1, 9, 0, 1);
    tick(1, 9, 0, 1);
    tick(1, 9, 1, 1);
    tick(1, 1, 0, 1);
    tick(1, 1, 0, 1);
    tick(1, 1, 0, 1);
    chk("clr_no_frame", int'(frame_val), 0);
    tick(1, 1, 0, 1);
    tick(0, 0, 0, 1);
    chk("clr_val", int'(frame_val), 1);
    chk("clr_sum", int'(sum), 4);
    chk("clr_min", int'(mn), 1);
    chk("clr_max", int'(mx), 1);
    chk("clr_ovf", int'(ovf), 1);
    chk("clr_rerr", int'(range_err), 0);
    tick(1, 40, 0, 1);
    tick(1, 0, 0, 1);
    chk("range_set", int'(range_err), 1);
    tick(1, 0, 0, 1);
    tick(1, 0, 0, 1);
    tick(0, 0, 0, 1);
    chk("range_val", int'(frame_val), 1);
    chk("range_sum", int'(sum), 32);
    chk("range_max", int'(mx), 32);
    chk("range_min", int'(mn), 0);
    tick(0, 0, 0, 1);
    chk("range_sticky", int'(range_err), 1);
    tick(1, 3, 0, 1);
    tick(1, 3, 0, 1);
    #2;
    data_val = 1'b0;
    arst_n = 1'b0;
    #1;
    chk_all_zero("arst");
    @(negedge clk);
    arst_n = 1'b1;
    repeat (4) tick(1, 6, 0, 1);
    tick(0, 0, 0, 1);
    chk("post_rst_val", int'(frame_val), 1);
    chk("post_rst_sum", int'(sum), 24);
    chk("post_rst_ovf", int'(ovf), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/ones_stat.md
# ones_stat

Downstream stage of the word popcount block. It consumes one ones-count per `data_val_i` pulse and accumulates FRAME_LEN consecutive counts into a frame. Per frame it reports the sum, minimum and maximum through a held valid/ready output register. It gives per-frame bit-density statistics to the status/readout logic, which may stall.

## Interface
- WIDTH, default 32: data word width of the upstream popcount stage; the largest legal input count.
- FRAME_LEN, default 16: counts per frame, ≥1.
- CNT_W, default $clog2(WIDTH)+2: input count width, identical to the upstream `data_o` width.
- SUM_W, default $clog2(FRAME_LEN*WIDTH+1): width of the frame sum.

Ports:
- clk_i  in  1  single clock, rising edge.
- arst_n_i  in  1  asynchronous, active-low reset.
- data_val_i  in  1  one-cycle strobe: `data_i` is valid; no backpressure to upstream.
- data_i  in  CNT_W  ones-count from the popcount stage.
- clr_i  in  1  synchronous clear: discards the partial frame.
- frame_rdy_i  in  1  consumer ready.
- frame_val_o  out  1  frame result valid; held until accepted.
- sum_o  out  SUM_W  sum of the FRAME_LEN counts.
- min_o  out  CNT_W  smallest count in the frame.
- max_o  out  CNT_W  largest count in the frame.
- drop_o  out  1  one-cycle pulse: a completed frame was discarded.
- ovf_o  out  1  sticky: at least one frame dropped since reset.
- range_err_o  out  1  sticky: an input count greater than WIDTH was received.

## Operation
- Accumulator section; all updates only on accepted samples (`data_val_i`=1):
  - index register idx, range 0..FRAME_LEN-1;
  - acc_sum, acc_min, acc_max.
- Sample handling:
  - idx==0: load acc_sum=data_i, acc_min=data_i, acc_max=data_i.
  - otherwise: add to acc_sum; update acc_min/acc_max with unsigned compares.
- Out-of-range input (data_i > WIDTH): sets range_err_o; the value is used saturated to WIDTH.
- Frame completion: a sample accepted with idx==FRAME_LEN-1 ("last"), including that sample's contribution. idx then wraps to 0.
- Output section, two states:
  - EMPTY: frame_val_o=0.
  - FULL: frame_val_o=1; sum_o/min_o/max_o stable and unchanged.
- Transitions:
  - EMPTY → FULL on last: output register loaded.
  - FULL → EMPTY on frame_rdy_i=1 with no last in the same cycle.
  - FULL with frame_rdy_i=1 and last in the same cycle: the new frame is loaded and the state stays FULL. No drop.
  - FULL with frame_rdy_i=0 and last: the new frame is discarded, drop_o pulses, ovf_o is set. Output register unchanged. Accumulation continues with the next frame.
- clr_i=1:
  - idx forced to 0; the partial frame is discarded.
  - A `data_val_i` in the same cycle is ignored.
  - Output register, frame_val_o, ovf_o and range_err_o are unaffected.
  - clr_i wins over a coincident last: no frame is produced, no drop.
- FRAME_LEN=1: every accepted sample completes a frame; sum=min=max=data_i (saturated).

## Timing
- Asynchronous reset (arst_n_i=0), effective immediately, without a clock edge:
  - all outputs 0: frame_val_o, sum_o, min_o, max_o, drop_o, ovf_o, range_err_o;
  - idx=0, output state EMPTY.
- Reset mid-frame: the partial frame is lost. The first sample after release starts a new frame.
- Latency: frame_val_o rises on the clock edge that accepts the last sample, i.e. it is visible the cycle after `data_val_i` of the last sample.
- Handshake: a transfer occurs on a rising edge where frame_val_o=1 and frame_rdy_i=1. frame_val_o never drops without a transfer.
- drop_o is high for exactly the one cycle following the discarded completion.
- Samples may arrive every cycle; full throughput with no bubbles.
- Arithmetic: all unsigned. SUM_W guarantees no sum overflow for saturated inputs.

## Test plan
Benches use WIDTH=32, FRAME_LEN=4.
- Reset: drive arst_n_i=0 between edges → all outputs 0 immediately. After release, frame_val_o stays 0 with no input.
- Basic frame: inputs 3,7,0,32 on consecutive cycles, frame_rdy_i=1 → frame_val_o=1 for one cycle, sum_o=42, min_o=0, max_o=32.
- Stall/drop: 8 back-to-back inputs 5 with frame_rdy_i=0 →
  - first frame held at sum=20, min=5, max=5;
  - drop_o pulses once at the 8th sample, ovf_o=1.
  - Then raise frame_rdy_i → one transfer, frame_val_o=0, ovf_o stays 1.
- Coincident handshake: hold frame 1,1,1,1 (sum=4). Raise frame_rdy_i on the same cycle the last sample of frame 2,2,2,2 is accepted → frame_val_o stays 1, sum_o=8, no drop_o.
- Clear: inputs 9,9, then clr_i=1, then inputs 1,1,1,1 → single frame with sum_o=4, min_o=1, max_o=1.
- Range: inputs 40,0,0,0 → range_err_o=1 sticky, sum_o=32, max_o=32.
